// File: rtl/nsa_pkg.sv
// ---------------------------------------------------------------------------
// nsa_pkg
// Shared types and constants for the nibble-serial adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   NIBBLE_W  : width of one adder slice step
//   nib_count : number of nibble steps for a given operand width
// ---------------------------------------------------------------------------
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a4, b4 : nibble operands
//   ci     : carry in
//   s4     : nibble sum
//   co     : carry out of bit 3
//   c3     : carry into bit 3 (used for signed overflow of the top nibble)
// ---------------------------------------------------------------------------
module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a4 & b4;
    assign p = a4 ^ b4;

    // Flattened lookahead terms: every carry comes straight from g/p/ci.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s4 = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Sequential WIDTH-bit adder: one 4-bit lookahead slice, one nibble per clock,
// carry registered between nibbles. Valid/ready on both sides.
//
// Optional build macro: NIBBLE_SERIAL_ADDER_OVF_EN adds port ovf (signed
// overflow of the full-width add, registered with cout).
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands offered
//   in_ready  : operands accepted (high only in IDLE)
//   a, b, cin : operands and LSB carry in, sampled on the accepting edge
//   out_valid : result available (DONE)
//   out_ready : sink takes result
//   sum, cout : registered result
//   ovf       : (optional) two's-complement overflow
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | adding nibble k = cnt_q each cycle, writing sum nibble k
// DONE  | result held, out_valid high until out_ready
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = nib_count(WIDTH);
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  carry_q;
    logic [CW-1:0]         cnt_q;
    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   s_nib;
    logic                  co_nib;
    logic                  c3_nib;
    logic                  accept;
    logic                  step;
    logic                  last;

    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN);
    assign last   = step && (cnt_q == LAST);

    assign a_nib = a_q[int'(cnt_q) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(cnt_q) * NIBBLE_W +: NIBBLE_W];

    cla4_slice u_slice (
        .a4 (a_nib),
        .b4 (b_nib),
        .ci (carry_q),
        .s4 (s_nib),
        .co (co_nib),
        .c3 (c3_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // sum is not cleared on accept: nibbles not yet processed keep their
    // previous value and only become meaningful once the run completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            sum[int'(cnt_q) * NIBBLE_W +: NIBBLE_W] <= s_nib;
            carry_q <= co_nib;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                cout <= co_nib;
            end
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= c3_nib ^ co_nib;
        end
    end
`else
    logic unused_c3_nib;
    assign unused_c3_nib = c3_nib;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
    logic [3:0]  a4, b4, sum4;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf, ovf4;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .ovf     (ovf)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .ovf     (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: {cout, sum} = a + b + cin modulo 2^w, plain integer arithmetic.
    function automatic logic [16:0] ref_add(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic c);
        longint m, t;
        m = (longint'(1) << w);
        t = (longint'(x) % m) + (longint'(y) % m) + longint'(c);
        return {(t >= m) ? 1'b1 : 1'b0, 16'(t % m)};
    endfunction

    // Reference: signed result out of the w-bit two's-complement range.
    function automatic logic ref_ovf(input int w, input logic [15:0] x,
                                     input logic [15:0] y, input logic c);
        longint m, h, sx, sy, s;
        m  = (longint'(1) << w);
        h  = m / 2;
        sx = longint'(x) % m;
        sy = longint'(y) % m;
        if (sx >= h) sx = sx - m;
        if (sy >= h) sy = sy - m;
        s = sx + sy + longint'(c);
        return (s >= h) || (s < -h);
    endfunction

    // Directed op on the 16-bit instance, optional backpressure in DONE.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] esum, input logic ecout,
                         input int stall);
        int lat;
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(16, ta, tb, tc)));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_sum"}, 32'(sum), 32'(esum));
            check({tag, "_stall_cout"}, 32'(cout), 32'(ecout));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // Back-to-back random ops, in_valid/out_ready held high.
    task automatic rand_run(input bit w4, input int nops);
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic        qc[$];
        logic [15:0] ra, rb, ea, eb;
        logic        rc, ec;
        logic [16:0] r;
        int w, gap, cyc, nres, last_acc;
        w = w4 ? 4 : 16;
        gap = w / 4 + 2;
        cyc = 0; nres = 0; last_acc = -1;
        if (w4) begin in_valid4 = 1'b1; out_ready4 = 1'b1; end
        else    begin in_valid  = 1'b1; out_ready  = 1'b1; end
        while (nres < nops && cyc < nops * gap + 50) begin
            if (w4 ? out_valid4 : out_valid) begin
                if (qa.size() == 0) begin
                    check("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    r = ref_add(w, ea, eb, ec);
                    if (w4) begin
                        check("rand4_sum", 32'(sum4), 32'(r[15:0]));
                        check("rand4_cout", 32'(cout4), 32'(r[16]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        check("rand4_ovf", 32'(ovf4), 32'(ref_ovf(w, ea, eb, ec)));
`endif
                    end else begin
                        check("rand16_sum", 32'(sum), 32'(r[15:0]));
                        check("rand16_cout", 32'(cout), 32'(r[16]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        check("rand16_ovf", 32'(ovf), 32'(ref_ovf(w, ea, eb, ec)));
`endif
                    end
                    nres++;
                end
            end
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (w4) ra[15:4] = '0;
            if (w4) rb[15:4] = '0;
            if (w4) begin a4 = ra[3:0]; b4 = rb[3:0]; cin4 = rc; end
            else    begin a = ra; b = rb; cin = rc; end
            if (w4 ? in_ready4 : in_ready) begin
                qa.push_back(ra); qb.push_back(rb); qc.push_back(rc);
                if (last_acc >= 0)
                    check(w4 ? "rand4_accept_gap" : "rand16_accept_gap",
                          32'(cyc - last_acc), 32'(gap));
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check(w4 ? "rand4_results" : "rand16_results", 32'(nres), 32'(nops));
        if (w4) in_valid4 = 1'b0; else in_valid = 1'b0;
        repeat (gap + 2) @(posedge clk);
        #1;
        if (w4) out_ready4 = 1'b0; else out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #23;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst4_in_ready", 32'(in_ready4), 32'd1);
        check("rst4_sum", 32'(sum4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        do_op("mixed", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0);
        do_op("backpressure", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 5);

        // Asynchronous reset after two nibbles of a run.
        a = 16'h9999; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        do_op("postrst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
        check("ovf_pos_flag", 32'(ovf), 32'd1);
        do_op("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0);
        check("ovf_neg_flag", 32'(ovf), 32'd1);
        do_op("ovf_none", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);
        check("ovf_none_flag", 32'(ovf), 32'd0);
`endif

        rand_run(1'b0, 1000);
        rand_run(1'b1, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
